matmult_stream_ctrl: RTL and testbench

//  Stream front/back end for the 3x3 registered matmult stage. Accepts 18 operand words on a

---
 rtl/matmult_stream_ctrl_pkg.sv | 34 +++
 rtl/matmult_stream_ctrl_result_buf.sv | 35 +++
 rtl/matmult_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matmult_stream_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmult_stream_ctrl_pkg.sv
// Shared constants and state encoding for the matmult stream controller.
// Imported by the controller top and its result buffer.
package matmult_stream_ctrl_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MM_N          = 3;
  localparam int MM_ELEMS      = MM_N * MM_N;
  localparam int OPERAND_WORDS = 2 * MM_ELEMS;
  localparam int IDX_W         = 5;
  localparam int OCNT_W        = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] idx_next(
    input logic [IDX_W-1:0] i
  );
    if (i == IDX_W'(OPERAND_WORDS - 1))
      return '0;
    return i + IDX_W'(1);
  endfunction

  function automatic logic [OCNT_W-1:0] ocnt_next(
    input logic [OCNT_W-1:0] i
  );
    if (i == OCNT_W'(MM_ELEMS - 1))
      return '0;
    return i + OCNT_W'(1);
  endfunction

endpackage

// File: rtl/matmult_stream_ctrl_result_buf.sv
// Result snapshot for the matmult stream controller: parallel load
// of all nine C words, word-select read on the drain counter.
module mm_result_buf
  import matmult_stream_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [MM_ELEMS*DATA_W-1:0] c,
  input  logic [OCNT_W-1:0]          sel,
  output logic [DATA_W-1:0]          data
);

  logic [DATA_W-1:0] mem [MM_ELEMS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MM_ELEMS; k++)
        mem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < MM_ELEMS; k++)
        mem[k] <= c[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < MM_ELEMS; k++)
      if (sel == OCNT_W'(k))
        data = mem[k];
  end

endmodule

// File: rtl/matmult_stream_ctrl.sv
// Stream front/back end for the 3x3 registered matmult: loads 18
// operand words, waits out matmult latency, drains 9 results.
module matmult_stream_ctrl
  import matmult_stream_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       abort,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [MM_ELEMS*DATA_W-1:0] mm_a,
  output logic [MM_ELEMS*DATA_W-1:0] mm_b,
  input  logic [MM_ELEMS*DATA_W-1:0] mm_c,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy
);

  localparam int WCNT_W = $clog2(MM_LATENCY + 2);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [OCNT_W-1:0] ocnt_q;
  logic [DATA_W-1:0] a_q [MM_ELEMS];
  logic [DATA_W-1:0] b_q [MM_ELEMS];

  logic in_fire;
  logic out_fire;
  logic last_in;
  logic last_out;
  logic wait_done;
  logic capture;

  // abort masks both handshakes so a word seen that cycle is dropped
  assign in_fire   = in_valid & in_ready & ~abort;
  assign out_fire  = out_valid & out_ready & ~abort;
  assign last_in   = idx_q == IDX_W'(OPERAND_WORDS - 1);
  assign last_out  = ocnt_q == OCNT_W'(MM_ELEMS - 1);
  assign wait_done = (state_q == ST_WAIT) &&
                     (wcnt_q == WCNT_W'(MM_LATENCY));
  assign capture   = wait_done & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_LOAD;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_LOAD:
          if (in_fire && last_in)
            state_d = ST_WAIT;
        ST_WAIT:
          if (wait_done)
            state_d = ST_DRAIN;
        ST_DRAIN:
          if (out_fire && last_out)
            state_d = ST_LOAD;
        default:
          state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = last_out;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wcnt_q <= '0;
      ocnt_q <= '0;
    end else if (abort) begin
      idx_q  <= '0;
      wcnt_q <= '0;
      ocnt_q <= '0;
    end else begin
      if (in_fire)
        idx_q <= idx_next(idx_q);
      if (in_fire && last_in)
        wcnt_q <= '0;
      else if (wait_done)
        wcnt_q <= '0;
      else if (state_q == ST_WAIT)
        wcnt_q <= wcnt_q + WCNT_W'(1);
      if (capture)
        ocnt_q <= '0;
      else if (out_fire)
        ocnt_q <= ocnt_next(ocnt_q);
    end
  end

  // operands persist across jobs until overwritten slot by slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MM_ELEMS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (in_fire) begin
      for (int k = 0; k < MM_ELEMS; k++) begin
        if (idx_q == IDX_W'(k))
          a_q[k] <= in_data;
        if (idx_q == IDX_W'(k + MM_ELEMS))
          b_q[k] <= in_data;
      end
    end
  end

  for (genvar g = 0; g < MM_ELEMS; g++) begin : g_pack
    assign mm_a[g*DATA_W +: DATA_W] = a_q[g];
    assign mm_b[g*DATA_W +: DATA_W] = b_q[g];
  end

  mm_result_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (capture),
    .c     (mm_c),
    .sel   (ocnt_q),
    .data  (out_data)
  );

endmodule

// File: tb/tb_matmult_stream_ctrl.sv
// Bench for matmult_stream_ctrl with behavioural 3x3 matmult models
// at latency 1 (main instance) and latency 3 (second instance).
module tb_matmult_stream_ctrl;

  localparam int W = 32;

  typedef logic [8:0][W-1:0] mat_t;

  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    mat_t  exp;
    bit    stall;
    int    lat;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  vec_t tbl[4];
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  mat_t         mm_a;
  mat_t         mm_b;
  mat_t         mm_c;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  logic         abort3;
  logic [W-1:0] in_data3;
  logic         in_valid3;
  logic         in_ready3;
  mat_t         mm_a3;
  mat_t         mm_b3;
  mat_t         mm_c3;
  logic [W-1:0] out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic         out_last3;
  logic         busy3;

  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  function automatic mat_t mm(input mat_t a, input mat_t b);
    mat_t         c;
    logic [W-1:0] p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        c[i*3+j] = '0;
        for (int m = 0; m < 3; m++) begin
          p = a[i*3+m] * b[m*3+j];
          c[i*3+j] = c[i*3+j] + p;
        end
      end
    return c;
  endfunction

  mat_t q1;
  mat_t q2;
  mat_t q3;

  always_ff @(posedge clk) begin
    mm_c <= mm(mm_a, mm_b);
    q1   <= mm(mm_a3, mm_b3);
    q2   <= q1;
    q3   <= q2;
  end

  assign mm_c3 = q3;

  matmult_stream_ctrl #(.DATA_W(W), .MM_LATENCY(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_c      (mm_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  matmult_stream_ctrl #(.DATA_W(W), .MM_LATENCY(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mm_a      (mm_a3),
    .mm_b      (mm_b3),
    .mm_c      (mm_c3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_last  (out_last3),
    .busy      (busy3)
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (stall_prev) begin
      chk("stall_valid", W'(out_valid), W'(1));
      chk("stall_data", out_data, prev_data);
    end
    if (out_valid)
      chk("in_ready_drain", W'(in_ready), W'(0));
    if (out_valid && out_ready && !abort) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", W'(out_valid), W'(0));
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", W'(out_last), W'(e.l));
      end
    end
    stall_prev = out_valid && !out_ready && !abort;
    prev_data  = out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input mat_t a, input mat_t b, input int nwords);
    int n;
    for (int w = 0; w < nwords; w++) begin
      if (w < 9) in_data = a[w];
      else       in_data = b[w-9];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) chk("in_ready_timeout", W'(0), W'(1));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input mat_t e);
    exp_t x;
    for (int k = 0; k < 9; k++) begin
      x.d = e[k];
      x.l = (k == 8);
      sbq.push_back(x);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_job(input vec_t v);
    int lat;
    int n;
    push_exp(v.exp);
    out_ready = 1'b1;
    feed(v.a, v.b, 18);
    wait_valid(lat);
    chk({v.name, "_latency"}, W'(lat), W'(v.lat));
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      chk({v.name, "_drain_timeout"}, W'(sbq.size()), W'(0));
      sbq.delete();
    end
    out_ready = 1'b1;
    chk({v.name, "_in_ready_after"}, W'(in_ready), W'(1));
    chk({v.name, "_busy_after"}, W'(busy), W'(0));
  endtask

  initial begin : main
    int e3[9];
    int lat;
    int n;
    e3 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    tbl[0].name = "ident";
    tbl[1].name = "allones";
    tbl[2].name = "stall";
    tbl[3].name = "twoI";
    for (int k = 0; k < 9; k++) begin
      tbl[0].a[k]   = (k % 4 == 0) ? W'(1) : W'(0);
      tbl[0].b[k]   = W'(k + 1);
      tbl[0].exp[k] = W'(k + 1);
      tbl[1].a[k]   = '1;
      tbl[1].b[k]   = '1;
      tbl[1].exp[k] = W'(3);
      tbl[2].a[k]   = W'(k + 1);
      tbl[2].b[k]   = W'(9 - k);
      tbl[2].exp[k] = W'(e3[k]);
      tbl[3].a[k]   = (k % 4 == 0) ? W'(2) : W'(0);
      tbl[3].b[k]   = W'(k + 1);
      tbl[3].exp[k] = W'(2 * (k + 1));
    end
    for (int i = 0; i < 4; i++) begin
      tbl[i].stall = (i == 2);
      tbl[i].lat   = 2;
    end

    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    abort3    = 1'b0;
    in_valid3 = 1'b0;
    in_data3  = '0;
    out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_mm_a", W'(|mm_a), W'(0));
    chk("rst_mm_b", W'(|mm_b), W'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++)
      run_job(tbl[i]);

    // abort part-way through loading; the word offered that cycle is dropped
    feed(tbl[2].a, tbl[2].b, 11);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_load_in_ready", W'(in_ready), W'(1));
    chk("abort_load_busy", W'(busy), W'(0));
    run_job(tbl[3]);

    // abort part-way through draining
    push_exp(tbl[1].exp);
    feed(tbl[1].a, tbl[1].b, 18);
    wait_valid(lat);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drain_valid", W'(out_valid), W'(0));
    chk("abort_drain_busy", W'(busy), W'(0));
    chk("abort_drain_popped", W'(sbq.size()), W'(6));
    sbq.delete();
    run_job(tbl[0]);

    // async reset with four results already drained
    push_exp(tbl[2].exp);
    feed(tbl[2].a, tbl[2].b, 18);
    wait_valid(lat);
    n = 0;
    while (sbq.size() > 5 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_popped", W'(sbq.size()), W'(5));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", W'(out_valid), W'(0));
    chk("rst_mid_busy", W'(busy), W'(0));
    chk("rst_mid_in_ready", W'(in_ready), W'(1));
    sbq.delete();
    stall_prev = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_job(tbl[2]);

    // latency-3 instance, identity job
    for (int w = 0; w < 18; w++) begin
      if (w < 9) in_data3 = tbl[0].a[w];
      else       in_data3 = tbl[0].b[w-9];
      in_valid3 = 1'b1;
      n = 0;
      while (!in_ready3 && n < 50) begin
        tick();
        n++;
      end
      tick();
    end
    in_valid3 = 1'b0;
    lat = 0;
    while (!out_valid3 && lat < 50) begin
      tick();
      lat++;
    end
    chk("lat3_latency", W'(lat), W'(4));
    for (int k = 0; k < 9; k++) begin
      chk("lat3_data", out_data3, tbl[0].exp[k]);
      chk("lat3_last", W'(out_last3), W'(k == 8));
      tick();
    end
    chk("lat3_busy_after", W'(busy3), W'(0));
    chk("lat3_in_ready_after", W'(in_ready3), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
